// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state types, forward and inverse S-box tables,
// byte-lane helper, and the SubBytes sequencer state encoding.
package aes_pkg;

  localparam int AES_BYTE_W  = 8;
  localparam int AES_STATE_W = 128;

  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;
  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sbs_state_t;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Used by the decryption-side InvSubBytes stage.
  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic aes_byte_t get_byte(input aes_state_t s, input int idx);
    return s[idx*AES_BYTE_W +: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: purely combinational table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Forward AES SubBytes engine: accepts a 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per clock, and hands the result off over valid/ready.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  sbs_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  aes_state_t       hold_reg;
  aes_state_t       out_reg;
  logic             load_en;
  logic             write_en;

  aes_byte_t lane_in  [BYTES_PER_CYCLE];
  aes_byte_t lane_out [BYTES_PER_CYCLE];

  // Lane gi of step cnt handles byte cnt*B+gi of the held word.
  for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
    assign lane_in[gi] = get_byte(hold_reg, int'(cnt_reg) * BYTES_PER_CYCLE + gi);
    aes_sbox u_sbox (
      .in_byte  (lane_in[gi]),
      .out_byte (lane_out[gi])
    );
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    load_en        = 1'b0;
    write_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          load_en    = 1'b1;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        write_en = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next     = ST_DONE;
          out_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      hold_reg      <= '0;
      out_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      if (load_en) hold_reg <= in_state;
      if (write_en) begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
          out_reg[(int'(cnt_reg) * BYTES_PER_CYCLE + i) * AES_BYTE_W +: AES_BYTE_W] <= lane_out[i];
        end
      end
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = out_valid_reg;
  assign out_state = out_reg;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (4, 1 and 16 bytes per cycle) checked
// against a GF(2^8)-derived S-box model plus directed FIPS-197 vectors.
module tb_sub_bytes_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int BPC = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
    sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_state  (in_state[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_state (out_state[gi]),
      .busy      (busy[gi])
    );
  end

  int checks = 0;
  int errors = 0;
  int steps [3] = '{4, 16, 1};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference S-box from first principles: multiplicative inverse + affine map.
  logic [7:0] ref_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] sub_word(input logic [127:0] w);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[w[8*i +: 8]];
    return r;
  endfunction

  // Transaction-level model: accept in idle, result NUM_STEPS edges later, drain on out_ready.
  logic         started = 1'b0;
  logic         m_busy  [3];
  logic         m_valid [3];
  logic         m_known [3];
  int           m_cd    [3];
  logic [127:0] m_exp   [3];
  logic [127:0] m_out   [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0; m_valid[k] <= 1'b0; m_cd[k] <= 0;
        m_out[k] <= '0; m_known[k] <= 1'b1;
      end else if (!m_busy[k]) begin
        if (in_valid[k]) begin
          m_busy[k] <= 1'b1; m_cd[k] <= steps[k];
          m_exp[k] <= sub_word(in_state[k]); m_known[k] <= 1'b0;
        end
      end else if (!m_valid[k]) begin
        if (m_cd[k] == 1) begin
          m_valid[k] <= 1'b1; m_out[k] <= m_exp[k]; m_known[k] <= 1'b1;
        end else begin
          m_cd[k] <= m_cd[k] - 1;
        end
      end else if (out_ready[k]) begin
        m_valid[k] <= 1'b0; m_busy[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("mdl_in_ready[%0d]", k), in_ready[k], !m_busy[k]);
        chk($sformatf("mdl_busy[%0d]", k), busy[k], m_busy[k]);
        chk($sformatf("mdl_out_valid[%0d]", k), out_valid[k], m_valid[k]);
        if (m_known[k]) chk($sformatf("mdl_out_state[%0d]", k), out_state[k], m_out[k]);
      end
    end
  end

  // Waits for out_valid after an accepting edge; returns edge count and data.
  task automatic wait_result(input int k, output int lat, output logic [127:0] got);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[k] && lat < 40);
    got = out_state[k];
  endtask

  task automatic run_word(input int k, input string name, input logic [127:0] word,
                          input logic [127:0] exp, output logic [127:0] got);
    int n, lat;
    n = 0;
    while (!in_ready[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s_ready[%0d]", name, k), in_ready[k], 1'b1);
    in_valid[k] = 1'b1;
    in_state[k] = word;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_state[k] = {$urandom, $urandom, $urandom, $urandom};
    wait_result(k, lat, got);
    $display("txn inst%0d %s in=%h out=%h latency=%0d", k, name, word, got, lat);
    chk($sformatf("%s_latency[%0d]", name, k), 128'(lat), 128'(steps[k]));
    chk($sformatf("%s_data[%0d]", name, k), got, exp);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] RT_IN    = 128'h00000000000000000000000ff265e022;
  localparam logic [127:0] RT_OUT   = 128'h636363636363636363636376894de193;

  initial begin
    logic [127:0] got, held, back;
    int lat;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    chk("model_sbox_00", 128'(ref_sbox[8'h00]), 128'h63);
    chk("model_sbox_01", 128'(ref_sbox[8'h01]), 128'h7c);
    chk("model_sbox_53", 128'(ref_sbox[8'h53]), 128'hed);
    chk("model_sbox_ff", 128'(ref_sbox[8'hff]), 128'h16);
    chk("model_fips", sub_word(FIPS_IN), FIPS_OUT);

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_state[k] = '0; out_ready[k] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), out_valid[k], 1'b0);
      chk($sformatf("rst_out_state[%0d]", k), out_state[k], '0);
      chk($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1'b1);
      chk($sformatf("rst_busy[%0d]", k), busy[k], 1'b0);
    end
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      run_word(k, "zeros", '0, {16{8'h63}}, got);
      run_word(k, "fips", FIPS_IN, FIPS_OUT, got);
    end

    run_word(0, "roundtrip", RT_IN, RT_OUT, got);
    for (int i = 0; i < 16; i++) back[8*i +: 8] = INV_SBOX[got[8*i +: 8]];
    chk("roundtrip_inverse", back, RT_IN);

    // Backpressure: result held in DONE, competing in_valid ignored.
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_state[0] = FIPS_IN;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_result(0, lat, held);
    chk("bp_data", held, FIPS_OUT);
    in_valid[0] = 1'b1;
    in_state[0] = {16{8'hff}};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid[0], 1'b1);
      chk("bp_hold_data", out_state[0], held);
      chk("bp_hold_in_ready", in_ready[0], 1'b0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", busy[0], 1'b0);
    chk("bp_release_valid", out_valid[0], 1'b0);
    @(posedge clk); #1;
    chk("bp_next_accepted", busy[0], 1'b1);
    in_valid[0] = 1'b0;
    wait_result(0, lat, got);
    $display("txn inst0 bp_next in=%h out=%h latency=%0d", {16{8'hff}}, got, lat);
    chk("bp_next_latency", 128'(lat), 128'd4);
    chk("bp_next_data", got, {16{8'h16}});
    @(posedge clk); #1;

    // Reset on the second RUN edge discards the word in flight.
    in_valid[0] = 1'b1;
    in_state[0] = FIPS_IN;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_out_state", out_state[0], '0);
    chk("midrst_in_ready", in_ready[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    run_word(0, "after_rst", {16{8'hff}}, {16{8'h16}}, got);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no_finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Forward AES SubBytes engine. It is the encryption-side counterpart of the inverse substitution stage.
- Takes one 128-bit state word over a valid/ready handshake and substitutes every byte through the forward Rijndael S-box.
- Processes BYTES_PER_CYCLE bytes per clock, so area trades against latency.
- Returns the result over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the iterative encryption datapath.

Parameters:
- BYTES_PER_CYCLE, 4, number of S-box lookups per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived localparam. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream has a state word.
- in_ready  out  1  engine can accept a word; high only in IDLE.
- in_state  in  128  input state. Byte i = in_state[8i+7:8i]; byte 0 is at the LSB.
- out_valid  out  1  out_state holds a complete result.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  substituted state, same byte packing as in_state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; step counter = 0.
  - Input holding register = 0; out_state = 0; out_valid = 0; in_ready = 1 after reset.
  - Reset takes priority over every other event, including a mid-RUN or DONE operation. The word in flight is discarded and no partial output is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch in_state into the holding register, clear the counter, go to RUN.
  - out_state keeps its previous value; it is don't-care while out_valid=0.
- RUN:
  - in_ready = 0.
  - Each edge writes bytes [cnt*B .. cnt*B+B-1] of out_state, where B = BYTES_PER_CYCLE. Each byte = Sbox(held byte) for the same index.
  - If cnt == NUM_STEPS-1, go to DONE and set out_valid = 1 on that same edge. Otherwise cnt = cnt+1.
  - Counter width is clog2(NUM_STEPS), with a minimum of 1 bit. The counter never wraps past NUM_STEPS-1.
- DONE:
  - out_valid = 1; out_state is stable and in_ready = 0.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - If out_ready stays 0, hold indefinitely with no data change.
- Latency: out_valid rises NUM_STEPS edges after the accepting edge (4 edges at the default; 1 at BYTES_PER_CYCLE=16).
- Throughput: one word per NUM_STEPS+2 cycles with out_ready tied high. No overlap of consecutive words.
- Input changes after acceptance have no effect, because the holding register isolates them.
- in_valid while busy is ignored. It is not an error; upstream must hold the word until in_ready.
- A simultaneous out_ready handshake in DONE and in_valid does not accept the new word that cycle. Acceptance happens in IDLE on a later edge.
- No X propagation: an X on in_state is only sampled at acceptance. The bench checks only clean inputs.
- S-box: pure combinational lookup of the forward FIPS-197 table, for example 00->63, 01->7C, 53->ED, FF->16.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BYTE_W = 8 and AES_STATE_W = 128.
  - A byte/state typedef.
  - The 256-entry forward S-box constant (SBOX). The inverse table lives in the same package for the decryption path.
  - A helper function for byte-lane extraction.
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational lookup of aes_pkg::SBOX. It is instantiated BYTES_PER_CYCLE times with a generate loop.
- In RUN, the lane mux selects the bytes at cnt*B.

Test Plan:
- Reset: hold rst for 2 cycles, then release. Required: out_valid=0, out_state=0, in_ready=1, busy=0.
- Single-byte sanity: in_state=0 (all bytes 00). Required: out_state = all bytes 63. out_valid rises exactly 4 edges after acceptance at the default parameter.
- FIPS-197 round-1 vector: input bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08. Required output bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Inverse round-trip: input bytes 0..4 = 22 e0 65 f2 0f and bytes 5..15 = 00. Required output bytes 0..4 = 93 e1 4d 89 76 and bytes 5..15 = 63. This result must pass back through the inverse stage to the original input.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE. Required: out_valid and out_state stable, in_ready=0, and a new in_valid is not accepted.
  - Then pulse out_ready. Required: IDLE on the next edge; the next word is accepted only after that.
- Reset mid-RUN: assert rst on the 2nd RUN edge. Required: IDLE, out_valid=0, out_state=0. A fresh word (all bytes FF) then yields all bytes 16.
- Repeat scenarios 2-3 with BYTES_PER_CYCLE=1 and 16. Required: latencies of 16 and 1 edges respectively, with identical data.
